// File: rtl/uart_pkg.sv
// Shared UART definitions: baud divider, receiver state encoding, word geometry.
// Pure definitions, no logic; no flow control.
package uart_pkg;

  localparam int BYTES_PER_WORD = 5;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  function automatic int baud_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver: 2-flop synchronizer, mid-bit sampling, byte_valid 1 cycle after the stop sample.
// No backpressure: byte_valid/byte_err are single-cycle strobes the consumer must take.
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = 434
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       uart_rx,
  output logic [7:0] byte_dat,
  output logic       byte_valid,
  output logic       byte_err
);

  localparam int HALF = BAUD_DIV / 2;
  localparam int CW   = $clog2(BAUD_DIV);

  logic          sync_q1, sync_q2, rx_prev;
  logic          fill_q1, fill_q2, armed;
  logic          fall;
  rx_state_t     state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    bit_idx, bit_idx_nxt;
  logic [7:0]    sh, sh_nxt;
  logic          vld_nxt, err_nxt;

  // fill_q2 marks the synchronizer as holding real samples, so the reset
  // value of the flops can neither arm the receiver nor fake a start edge.
  assign fall     = armed & rx_prev & ~sync_q2;
  assign byte_dat = sh;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      sync_q1    <= 1'b1;
      sync_q2    <= 1'b1;
      rx_prev    <= 1'b1;
      fill_q1    <= 1'b0;
      fill_q2    <= 1'b0;
      armed      <= 1'b0;
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      sh         <= '0;
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
    end else begin
      sync_q1    <= uart_rx;
      sync_q2    <= sync_q1;
      rx_prev    <= sync_q2;
      fill_q1    <= 1'b1;
      fill_q2    <= fill_q1;
      if (fill_q2 && sync_q2) armed <= 1'b1;
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      bit_idx    <= bit_idx_nxt;
      sh         <= sh_nxt;
      byte_valid <= vld_nxt;
      byte_err   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt + 1'b1;
    bit_idx_nxt = bit_idx;
    sh_nxt      = sh;
    vld_nxt     = 1'b0;
    err_nxt     = 1'b0;
    unique case (state)
      RX_IDLE: begin
        cnt_nxt = '0;
        if (fall) state_nxt = RX_START;
      end
      RX_START: begin
        if (cnt == CW'(HALF - 1)) begin
          cnt_nxt     = '0;
          bit_idx_nxt = '0;
          state_nxt   = sync_q2 ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt == CW'(BAUD_DIV - 1)) begin
          cnt_nxt     = '0;
          sh_nxt      = {sync_q2, sh[7:1]};
          bit_idx_nxt = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_nxt = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt == CW'(BAUD_DIV - 1)) begin
          cnt_nxt   = '0;
          state_nxt = RX_IDLE;
          vld_nxt   = sync_q2;
          err_nxt   = ~sync_q2;
        end
      end
      default: state_nxt = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_rx_data40.sv
// Assembles five received bytes (first byte LSB) into a 40-bit word; Rx_Done 1 cycle after the last byte_valid.
// No backpressure: Data40 holds the last word, pulses are single-cycle; partial frames dropped on error/gap.
module uart_rx_data40
  import uart_pkg::*;
#(
  parameter int CLK_FREQ      = 50_000_000,
  parameter int BAUD          = 115200,
  parameter int TIMEOUT_BYTES = 2
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        uart_rx,
  output logic [39:0] Data40,
  output logic        Rx_Done,
  output logic        Frame_Err,
  output logic        Timeout
);

  localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD);
  localparam int GAP_MAX  = TIMEOUT_BYTES * 10 * BAUD_DIV - 1;
  localparam int GW       = $clog2(GAP_MAX + 1);

  logic [7:0]    byte_dat;
  logic          byte_valid, byte_err;
  logic [2:0]    idx;
  logic [31:0]   asm_q;
  logic [GW-1:0] gap_cnt;
  logic          gap_hit;

  uart_byte_rx #(.BAUD_DIV(BAUD_DIV)) u_byte_rx (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .uart_rx    (uart_rx),
    .byte_dat   (byte_dat),
    .byte_valid (byte_valid),
    .byte_err   (byte_err)
  );

  assign gap_hit = (idx != 3'd0) && (gap_cnt == GW'(GAP_MAX));

  // Lanes 0..3 are staged; the last byte goes straight into Data40 so the
  // word lands in the same cycle as Rx_Done.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      idx       <= '0;
      asm_q     <= '0;
      gap_cnt   <= '0;
      Data40    <= '0;
      Rx_Done   <= 1'b0;
      Frame_Err <= 1'b0;
      Timeout   <= 1'b0;
    end else begin
      Rx_Done   <= 1'b0;
      Frame_Err <= 1'b0;
      Timeout   <= 1'b0;
      if (byte_valid) begin
        gap_cnt <= '0;
        if (idx == 3'(BYTES_PER_WORD - 1)) begin
          Data40  <= {byte_dat, asm_q};
          Rx_Done <= 1'b1;
          idx     <= '0;
        end else begin
          asm_q[{idx[1:0], 3'b000} +: 8] <= byte_dat;
          idx <= idx + 3'd1;
        end
      end else if (byte_err) begin
        idx       <= '0;
        gap_cnt   <= '0;
        Frame_Err <= 1'b1;
      end else if (gap_hit) begin
        idx     <= '0;
        gap_cnt <= '0;
        Timeout <= 1'b1;
      end else if (idx != 3'd0) begin
        gap_cnt <= gap_cnt + 1'b1;
      end else begin
        gap_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_data40.sv
// Directed bench for uart_rx_data40 at BAUD_DIV = 16 (1.6 MHz / 100 kBd), TIMEOUT_BYTES = 2.
module tb_uart_rx_data40;

  localparam int BIT_CYC  = 16;
  localparam int BYTE_CYC = 10 * BIT_CYC;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        uart_rx;
  logic [39:0] Data40;
  logic        Rx_Done, Frame_Err, Timeout;

  int checks = 0, errors = 0;
  int done_cnt = 0, ferr_cnt = 0, to_cnt = 0, excl_err = 0, hold_err = 0;
  logic [39:0] data_prev = '0;

  uart_rx_data40 #(
    .CLK_FREQ      (1_600_000),
    .BAUD          (100_000),
    .TIMEOUT_BYTES (2)
  ) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .uart_rx   (uart_rx),
    .Data40    (Data40),
    .Rx_Done   (Rx_Done),
    .Frame_Err (Frame_Err),
    .Timeout   (Timeout)
  );

  always #5 Clk = ~Clk;

  // Pulse counters plus exclusivity and Data40-hold watchers.
  always @(negedge Clk) begin
    if (Reset_n) begin
      if (Rx_Done)   done_cnt <= done_cnt + 1;
      if (Frame_Err) ferr_cnt <= ferr_cnt + 1;
      if (Timeout)   to_cnt   <= to_cnt + 1;
      if (int'(Rx_Done) + int'(Frame_Err) + int'(Timeout) > 1) excl_err <= excl_err + 1;
      if (Data40 !== data_prev && !Rx_Done) hold_err <= hold_err + 1;
    end
    data_prev <= Data40;
  end

  task automatic bit_time(input logic v);
    uart_rx = v;
    repeat (BIT_CYC) @(negedge Clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
    bit_time(stop_bit);
  endtask

  task automatic send_word(input logic [39:0] w);
    for (int i = 0; i < 5; i++) send_byte(w[i*8 +: 8], 1'b1);
  endtask

  task automatic idle(input int n);
    uart_rx = 1'b1;
    repeat (n) @(negedge Clk);
  endtask

  task automatic test_reset;
    Reset_n = 1'b0;
    uart_rx = 1'b1;
    repeat (4) @(negedge Clk);
    checks++; if (Data40 !== 40'h0) begin errors++; $display("FAIL reset_data: got %h expected %h", Data40, 40'h0); end
    checks++; if (Rx_Done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", Rx_Done); end
    checks++; if (Frame_Err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b expected 0", Frame_Err); end
    checks++; if (Timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", Timeout); end
    Reset_n = 1'b1;
    idle(10);
    checks++; if (done_cnt + ferr_cnt + to_cnt !== 0) begin errors++; $display("FAIL reset_idle_pulses: got %0d expected 0", done_cnt + ferr_cnt + to_cnt); end
  endtask

  task automatic test_single_frame;
    int d0, f0, t0;
    d0 = done_cnt; f0 = ferr_cnt; t0 = to_cnt;
    send_word(40'h89_6745_2301);
    idle(8);
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL single_done_count: got %0d expected 1", done_cnt - d0); end
    checks++; if (Data40 !== 40'h89_6745_2301) begin errors++; $display("FAIL single_data: got %h expected %h", Data40, 40'h89_6745_2301); end
    checks++; if ((ferr_cnt - f0) + (to_cnt - t0) !== 0) begin errors++; $display("FAIL single_err_pulses: got %0d expected 0", (ferr_cnt - f0) + (to_cnt - t0)); end
  endtask

  task automatic test_back_to_back;
    int d0;
    d0 = done_cnt;
    send_word(40'hEE_DDCC_BBAA);
    checks++; if (Data40 !== 40'hEE_DDCC_BBAA) begin errors++; $display("FAIL b2b_first_data: got %h expected %h", Data40, 40'hEE_DDCC_BBAA); end
    send_word(40'h55_4433_2211);
    idle(8);
    checks++; if (done_cnt - d0 !== 2) begin errors++; $display("FAIL b2b_done_count: got %0d expected 2", done_cnt - d0); end
    checks++; if (Data40 !== 40'h55_4433_2211) begin errors++; $display("FAIL b2b_second_data: got %h expected %h", Data40, 40'h55_4433_2211); end
  endtask

  task automatic test_frame_err;
    int d0, f0;
    d0 = done_cnt; f0 = ferr_cnt;
    send_byte(8'h10, 1'b1);
    send_byte(8'h20, 1'b1);
    send_byte(8'h30, 1'b0);
    idle(20);
    checks++; if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL ferr_count: got %0d expected 1", ferr_cnt - f0); end
    checks++; if (Data40 !== 40'h55_4433_2211) begin errors++; $display("FAIL ferr_data_held: got %h expected %h", Data40, 40'h55_4433_2211); end
    checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL ferr_no_done: got %0d expected 0", done_cnt - d0); end
    send_word(40'h0F_1E2D_3C4B);
    idle(8);
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL ferr_recover_done: got %0d expected 1", done_cnt - d0); end
    checks++; if (Data40 !== 40'h0F_1E2D_3C4B) begin errors++; $display("FAIL ferr_recover_data: got %h expected %h", Data40, 40'h0F_1E2D_3C4B); end
  endtask

  task automatic test_timeout;
    int d0, t0, lat;
    d0 = done_cnt; t0 = to_cnt; lat = -1;
    send_byte(8'h5A, 1'b1);
    send_byte(8'hC3, 1'b1);
    uart_rx = 1'b1;
    // byte_valid of byte 2 lands 4 cycles before send_byte returns; 320-cycle gap window.
    for (int i = 1; i <= 25 * BYTE_CYC; i++) begin
      @(negedge Clk);
      if (Timeout && lat < 0) lat = i;
    end
    checks++; if (lat !== 316) begin errors++; $display("FAIL timeout_latency: got %0d expected 316", lat); end
    checks++; if (to_cnt - t0 !== 1) begin errors++; $display("FAIL timeout_count: got %0d expected 1", to_cnt - t0); end
    checks++; if (Data40 !== 40'h0F_1E2D_3C4B) begin errors++; $display("FAIL timeout_data_held: got %h expected %h", Data40, 40'h0F_1E2D_3C4B); end
    send_word(40'hA5_9687_7869);
    idle(8);
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL timeout_done_count: got %0d expected 1", done_cnt - d0); end
    checks++; if (Data40 !== 40'hA5_9687_7869) begin errors++; $display("FAIL timeout_new_data: got %h expected %h", Data40, 40'hA5_9687_7869); end
  endtask

  task automatic test_glitch;
    int p0;
    p0 = done_cnt + ferr_cnt + to_cnt;
    uart_rx = 1'b0;
    repeat (5) @(negedge Clk);
    idle(2 * BYTE_CYC);
    checks++; if (done_cnt + ferr_cnt + to_cnt - p0 !== 0) begin errors++; $display("FAIL glitch_pulses: got %0d expected 0", done_cnt + ferr_cnt + to_cnt - p0); end
    checks++; if (dut.idx !== 3'd0) begin errors++; $display("FAIL glitch_idx: got %0d expected 0", dut.idx); end
    checks++; if (dut.u_byte_rx.byte_valid !== 1'b0) begin errors++; $display("FAIL glitch_byte_valid: got %b expected 0", dut.u_byte_rx.byte_valid); end
  endtask

  task automatic test_reset_mid_frame;
    int d0, f0, t0;
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    repeat (4) bit_time(1'b0);
    Reset_n = 1'b0;
    repeat (4) @(negedge Clk);
    Reset_n = 1'b1;
    d0 = done_cnt; f0 = ferr_cnt; t0 = to_cnt;
    repeat (3 * BYTE_CYC) @(negedge Clk);
    checks++; if ((done_cnt - d0) + (ferr_cnt - f0) + (to_cnt - t0) !== 0) begin errors++; $display("FAIL rstmid_pulses_low: got %0d expected 0", (done_cnt - d0) + (ferr_cnt - f0) + (to_cnt - t0)); end
    checks++; if (Data40 !== 40'h0) begin errors++; $display("FAIL rstmid_data_cleared: got %h expected %h", Data40, 40'h0); end
    idle(20);
    send_word(40'hF0_E1D2_C3B4);
    idle(8);
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL rstmid_done_count: got %0d expected 1", done_cnt - d0); end
    checks++; if (Data40 !== 40'hF0_E1D2_C3B4) begin errors++; $display("FAIL rstmid_data: got %h expected %h", Data40, 40'hF0_E1D2_C3B4); end
    checks++; if ((ferr_cnt - f0) + (to_cnt - t0) !== 0) begin errors++; $display("FAIL rstmid_err_pulses: got %0d expected 0", (ferr_cnt - f0) + (to_cnt - t0)); end
  endtask

  task automatic test_invariants;
    checks++; if (excl_err !== 0) begin errors++; $display("FAIL pulse_exclusive: got %0d overlaps expected 0", excl_err); end
    checks++; if (hold_err !== 0) begin errors++; $display("FAIL data_hold: got %0d changes without Rx_Done expected 0", hold_err); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_frame_err();
    test_timeout();
    test_glitch();
    test_reset_mid_frame();
    test_invariants();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_data40.md
# uart_rx_data40

Receive-side counterpart of the 40-bit UART transmit stage. Samples the serial line with an internal 8N1 byte receiver and assembles five consecutive bytes, first byte least significant, into one 40-bit word. Presents the word with a single-cycle done strobe. Partial frames are discarded on a framing error or an inter-byte timeout. Sits between the board RX pin and the user logic that consumes 40-bit commands or data.

## Interface
Parameters:
- CLK_FREQ, 50_000_000 — Clk frequency in Hz.
- BAUD, 115200 — line rate; BAUD_DIV = CLK_FREQ/BAUD, integer-truncated (434 at defaults).
- TIMEOUT_BYTES, 2 — maximum idle gap between bytes of one frame, in byte times (10 bit times each).

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  reset; synchronous, active-low.
- uart_rx  in  1  asynchronous serial input; idles high.
- Data40  out  40  last complete word. Byte 0 → [7:0], byte 4 → [39:32].
- Rx_Done  out  1  one-cycle pulse; Data40 is valid from this cycle onward.
- Frame_Err  out  1  one-cycle pulse when a stop bit is sampled low.
- Timeout  out  1  one-cycle pulse when a partial frame is abandoned because of a gap.

## Operation
Byte receiver (sub-module):
- uart_rx passes through a 2-flop synchronizer before any use.
- After reset, the receiver is armed only once the synchronized line has been high for 1 cycle.
- States: IDLE → START → DATA → STOP → IDLE.
- IDLE: a synchronized falling edge starts the baud counter and moves to START.
- START: sample at BAUD_DIV/2 cycles. If the line is high, treat it as a false start and return to IDLE; if low, go to DATA.
- DATA: sample every BAUD_DIV cycles. 8 bits, LSB first.
- STOP: sample after a further BAUD_DIV cycles.
  - Line high: byte_valid pulses for 1 cycle with the byte.
  - Line low: byte_err pulses for 1 cycle and the byte is dropped.
  - In both cases, return to IDLE; a new start edge is accepted on the next cycle.

Assembler:
- Holds a byte index idx (0..4) and a 40-bit shift/placement register.
- On byte_valid: write the byte into lane idx.
  - If idx == 4: load Data40 from the full register, pulse Rx_Done, set idx = 0.
  - Otherwise: idx += 1.
- On byte_err: idx = 0, pulse Frame_Err, keep Data40.
- Gap counter:
  - Cleared on every byte_valid.
  - Counts only while idx != 0.
  - On reaching TIMEOUT_BYTES*10*BAUD_DIV − 1: idx = 0, pulse Timeout, counter cleared.
- Simultaneous byte_valid and gap expiry in the same cycle: byte_valid wins and no Timeout pulse is issued.
- Data40 changes only on Rx_Done and holds its value otherwise.
- Partial-frame bytes never appear on Data40.

## Timing
- Reset values: Data40 = 0, Rx_Done = 0, Frame_Err = 0, Timeout = 0. Internally: idx = 0, receiver in IDLE, synchronizer flops = 1.
- Reset asserted mid-frame: all state is cleared on the next Clk edge and the partial frame is lost. No pulses are issued during reset.
- Latency:
  - Stop-bit sample → byte_valid: 1 cycle.
  - byte_valid → Rx_Done and Data40 update: 1 cycle.
  - Data40 and Rx_Done change in the same cycle.
- Sample points measured from the synchronized falling edge: start at BAUD_DIV/2, data bit n at BAUD_DIV/2 + (n+1)·BAUD_DIV, stop at BAUD_DIV/2 + 9·BAUD_DIV. The input path adds a fixed 2-cycle delay.
- Back-to-back frames with zero idle between stop and the next start bit must be received without loss.
- Rx_Done, Frame_Err and Timeout are mutually exclusive in any cycle.

## Structure
- Shared package uart_pkg:
  - BAUD_DIV computation function.
  - Receiver state encoding (IDLE/START/DATA/STOP).
  - Constant BYTES_PER_WORD = 5.
- Sub-module uart_byte_rx (synchronizer, baud counter, bit counter, byte_valid/byte_err). It mirrors uart_byte_tx and is reusable on its own.
- Top level holds only the assembler, the gap counter and the output registers.

## Test plan
- Reset, then send bytes 0x01, 0x23, 0x45, 0x67, 0x89 back-to-back at 115200 → one Rx_Done pulse; Data40 = 40'h89_6745_2301; no error pulses.
- Two frames back-to-back with zero inter-byte idle → two Rx_Done pulses; the second Data40 is correct; the first value is held until the second Rx_Done.
- Third byte sent with stop bit = 0 → one Frame_Err pulse, Data40 unchanged. A following clean 5-byte frame is assembled from scratch.
- Send 2 bytes, idle for 25 byte times, then send 5 bytes → one Timeout pulse ≈ 2 byte times after byte 2. Then exactly one Rx_Done containing only the 5 new bytes.
- Low glitch shorter than BAUD_DIV/2 cycles on an idle line → no byte_valid, no pulses, idx stays 0.
- Reset_n asserted during byte 3, line held low through the reset release, then released high and a full frame sent → no output before the line goes high. The frame is then received correctly.
